coordinate_scheduler: RTL and testbench
=======================================

# coordinate_scheduler

Sequences the coordinate computation datapath over a full layer tile: it walks every (weight group, activation group) pair of compressed index groups, outer loop over weight groups, inner loop over activation groups. For each pair it issues the group numbers, the lane count for the active bitwidth, and the running absolute base indices to the coordinate unit and its index buffers. Downstream backpressure is honoured with a valid/ready handshake. It sits between the layer control sequencer (start/abort) and the coordinate unit / index buffers.

## Interface
- No parameters; widths fixed below.
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel; priority over everything except reset
- bitwidth  in  2  00=16 lanes, 01=8, 10=4, 11=illegal; captured at start
- num_w_groups  in  8  weight groups in tile; captured at start
- num_a_groups  in  12  activation groups in tile; captured at start
- w_span  in  8  index span of weight group at w_group, combinational from weight index buffer
- a_span  in  8  index span of activation group at a_group, combinational from activation index buffer
- issue_valid  out  1  pair presented
- issue_ready  in  1  coordinate unit accepts pair
- w_group  out  8  current weight group number
- a_group  out  12  current activation group number
- w_base  out  16  absolute index of first element of w_group
- a_base  out  16  absolute index of first element of a_group
- lanes  out  5  16/8/4 per captured bitwidth
- first_a  out  1  a_group==0 (coordinate unit reloads activation running index)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of tile
- error  out  1  sticky: illegal bitwidth or base overflow; cleared by start or reset

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures the configuration and clears error.
  - Zero groups (num_w_groups==0 or num_a_groups==0): go to DONE, no issue.
  - bitwidth==11: set error, go to DONE, no issue.
  - Otherwise go to RUN with w_group=a_group=0 and w_base=a_base=0.
- RUN: issue_valid=1. Handshake = issue_valid & issue_ready.
  - No handshake: all outputs hold stable.
  - Handshake, a_group < num_a_groups-1: a_group+1, a_base += a_span.
  - Handshake on last a_group, w_group < num_w_groups-1: w_group+1, w_base += w_span, a_group=0, a_base=0.
  - Handshake on last pair: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. issue_valid=0.
- Arithmetic: bases are 16-bit unsigned sums that wrap mod 2^16. A carry out of bit 15 on either add sets error; the sequence still continues.
- lanes: 16/8/4 by captured bitwidth; 0 in IDLE.
- start outside IDLE is ignored. Config inputs are ignored after capture.
- abort=1 in any state: next cycle IDLE, issue_valid=0, no done pulse, counters/bases cleared, error kept.
- reset_n=0: at the next edge every output and register is 0 (issue_valid, busy, done, error, groups, bases, lanes), state IDLE. This applies mid-tile as well.

## Timing
- start at edge N: busy and issue_valid first high after edge N+1.
- Sustained throughput is one pair per cycle while issue_ready=1. A tile takes num_w_groups*num_a_groups issue cycles plus 1 done cycle.
- done is high in the cycle after the last handshake. busy drops in the cycle after done.
- Zero-group or illegal start: done in the cycle after the start edge, with no issue_valid.
- issue_ready may be high while issue_valid is low; it has no effect then.
- issue_valid never drops without a handshake, except on abort or reset.

## Test plan
- Normal tile: num_w=2, num_a=3, bitwidth=01, w_span=[5,7], a_span=[2,4,6], ready=1.
  - Required issues (w,a,wb,ab) in consecutive cycles: (0,0,0,0) (0,1,0,2) (0,2,0,6) (1,0,5,0) (1,1,5,2) (1,2,5,6).
  - lanes=8 throughout; first_a high on the 1st and 4th issue; done 7 cycles after start.
- Backpressure: same tile with ready toggling 1,0,0,1,…
  - Outputs stay frozen while ready=0.
  - Exactly 6 handshakes occur, in the same order.
  - done follows the 6th handshake by one cycle.
- Degenerate: num_a=0 → done one cycle after start, issue_valid never high. bitwidth=11 → done plus error=1, no issues. A following legal start clears error.
- Overflow: num_w=1, num_a=300, every a_span=255 → a_base wraps past 65535 at the 258th increment and error becomes 1 at that point. All 300 issues still complete.
- Abort/reset mid-tile: abort during issue 3 → idle next cycle, no done. Repeat with reset_n=0 during issue 3 → all outputs 0 next cycle. A subsequent start replays the tile from (0,0).
- start held high while busy: no restart; the tile completes normally.

Source files
------------

// File: rtl/coordinate_scheduler.sv
`default_nettype none
// ============================================================================
// coordinate_scheduler : walks every (weight, activation) index-group pair of a
// tile and issues group numbers, lane count and running base indices.
// Revision: 1.0
// ============================================================================
module coordinate_scheduler (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [1:0]  bitwidth,
   input  logic [7:0]  num_w_groups,
   input  logic [11:0] num_a_groups,
   input  logic [7:0]  w_span,
   input  logic [7:0]  a_span,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [7:0]  w_group,
   output logic [11:0] a_group,
   output logic [15:0] w_base,
   output logic [15:0] a_base,
   output logic [4:0]  lanes,
   output logic        first_a,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] C_BW_ILLEGAL = 2'b11;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_bitwidth;
   logic [7:0]  r_num_w;
   logic [11:0] r_num_a;
   logic [7:0]  r_w_group;
   logic [11:0] r_a_group;
   logic [15:0] r_w_base;
   logic [15:0] r_a_base;
   logic        r_error;

   logic        w_handshake;
   logic        w_last_a;
   logic        w_last_w;
   logic        w_zero_cfg;
   logic [16:0] w_a_sum;
   logic [16:0] w_w_sum;

   assign w_handshake = (r_state == S_RUN) && issue_ready;
   assign w_last_a    = (r_a_group == (r_num_a - 12'd1));
   assign w_last_w    = (r_w_group == (r_num_w - 8'd1));
   assign w_zero_cfg  = (num_w_groups == 8'd0) || (num_a_groups == 12'd0);
   // Bit 16 of each sum is the carry out that flags base overflow.
   assign w_a_sum     = {1'b0, r_a_base} + {9'd0, a_span};
   assign w_w_sum     = {1'b0, r_w_base} + {9'd0, w_span};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (w_zero_cfg || (bitwidth == C_BW_ILLEGAL)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_handshake && w_last_a && w_last_w) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (abort) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_bitwidth <= 2'd0;
         r_num_w    <= 8'd0;
         r_num_a    <= 12'd0;
         r_w_group  <= 8'd0;
         r_a_group  <= 12'd0;
         r_w_base   <= 16'd0;
         r_a_base   <= 16'd0;
         r_error    <= 1'b0;
      end else if (abort) begin
         r_w_group <= 8'd0;
         r_a_group <= 12'd0;
         r_w_base  <= 16'd0;
         r_a_base  <= 16'd0;
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_bitwidth <= bitwidth;
            r_num_w    <= num_w_groups;
            r_num_a    <= num_a_groups;
            r_w_group  <= 8'd0;
            r_a_group  <= 12'd0;
            r_w_base   <= 16'd0;
            r_a_base   <= 16'd0;
            r_error    <= (bitwidth == C_BW_ILLEGAL);
         end
      end else if (w_handshake) begin
         if (!w_last_a) begin
            r_a_group <= r_a_group + 12'd1;
            r_a_base  <= w_a_sum[15:0];
            if (w_a_sum[16]) begin
               r_error <= 1'b1;
            end
         end else if (!w_last_w) begin
            r_w_group <= r_w_group + 8'd1;
            r_w_base  <= w_w_sum[15:0];
            r_a_group <= 12'd0;
            r_a_base  <= 16'd0;
            if (w_w_sum[16]) begin
               r_error <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      lanes = 5'd0;
      if (r_state != S_IDLE) begin
         case (r_bitwidth)
            2'b00:   lanes = 5'd16;
            2'b01:   lanes = 5'd8;
            2'b10:   lanes = 5'd4;
            default: lanes = 5'd0;
         endcase
      end
   end

   assign issue_valid = (r_state == S_RUN);
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign w_group     = r_w_group;
   assign a_group     = r_a_group;
   assign w_base      = r_w_base;
   assign a_base      = r_a_base;
   // Gated by RUN so that a freshly reset block drives all outputs low.
   assign first_a     = (r_state == S_RUN) && (r_a_group == 12'd0);
   assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_coordinate_scheduler.sv
`default_nettype none
// ============================================================================
// tb_coordinate_scheduler : directed self-checking bench for coordinate_scheduler.
// Revision: 1.0
// ============================================================================
module tb_coordinate_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  bitwidth = 2'b00;
   logic [7:0]  num_w_groups = 8'd0;
   logic [11:0] num_a_groups = 12'd0;
   logic [7:0]  w_span;
   logic [7:0]  a_span;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [7:0]  w_group;
   logic [11:0] a_group;
   logic [15:0] w_base;
   logic [15:0] a_base;
   logic [4:0]  lanes;
   logic        first_a;
   logic        busy;
   logic        done;
   logic        error;

   logic        span_all_255 = 1'b0;
   int          errors = 0;
   int          checks = 0;

   logic [7:0]  exp_w  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
   logic [11:0] exp_a  [6] = '{12'd0, 12'd1, 12'd2, 12'd0, 12'd1, 12'd2};
   logic [15:0] exp_wb [6] = '{16'd0, 16'd0, 16'd0, 16'd5, 16'd5, 16'd5};
   logic [15:0] exp_ab [6] = '{16'd0, 16'd2, 16'd6, 16'd0, 16'd2, 16'd6};
   logic        exp_fa [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   coordinate_scheduler dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .bitwidth     (bitwidth),
      .num_w_groups (num_w_groups),
      .num_a_groups (num_a_groups),
      .w_span       (w_span),
      .a_span       (a_span),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .w_group      (w_group),
      .a_group      (a_group),
      .w_base       (w_base),
      .a_base       (a_base),
      .lanes        (lanes),
      .first_a      (first_a),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   // Index buffer model: spans looked up from the currently issued groups.
   always_comb begin
      w_span = 8'd0;
      a_span = 8'd0;
      case (w_group)
         8'd0:    w_span = 8'd5;
         8'd1:    w_span = 8'd7;
         default: w_span = 8'd0;
      endcase
      if (span_all_255) begin
         a_span = 8'd255;
      end else begin
         case (a_group)
            12'd0:   a_span = 8'd2;
            12'd1:   a_span = 8'd4;
            12'd2:   a_span = 8'd6;
            default: a_span = 8'd0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({issue_valid, busy, done, error, w_group, a_group, w_base, a_base, lanes, first_a} !== 61'd0) begin
         errors++;
         $display("FAIL reset_state got=%h want=0",
                  {issue_valid, busy, done, error, w_group, a_group, w_base, a_base, lanes, first_a});
      end
      reset_n = 1'b1;
      tick();
   endtask

   // Start the 2x3 reference tile and check every issue plus the done pulse.
   task automatic run_tile(input string name, input bit hold_start, input int ready_mode);
      logic [60:0] got;
      logic [60:0] want;
      int k;
      int cyc;
      num_w_groups = 8'd2;
      num_a_groups = 12'd3;
      bitwidth     = 2'b01;
      span_all_255 = 1'b0;
      issue_ready  = 1'b1;
      start        = 1'b1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_before_start busy=%b want=0", name, busy);
      end
      tick();
      if (!hold_start) start = 1'b0;
      k = 0;
      cyc = 0;
      while (k < 6 && cyc < 100) begin
         if (ready_mode == 1) issue_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         got  = {issue_valid, busy, done, w_group, a_group, w_base, a_base, lanes, first_a};
         want = {1'b1, 1'b1, 1'b0, exp_w[k], exp_a[k], exp_wb[k], exp_ab[k], 5'd8, exp_fa[k]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s_issue%0d cyc=%0d got=%h want=%h", name, k, cyc, got, want);
         end
         tick();
         if (issue_ready) k++;
         cyc++;
      end
      start = 1'b0;
      issue_ready = 1'b1;
      checks++;
      if (k != 6) begin
         errors++;
         $display("FAIL %s_handshake_count got=%0d want=6", name, k);
      end
      checks++;
      if ({done, issue_valid, busy, error} !== 4'b1010) begin
         errors++;
         $display("FAIL %s_done got=%b want=1010", name, {done, issue_valid, busy, error});
      end
      tick();
      checks++;
      if ({done, issue_valid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL %s_idle_after got=%b want=000", name, {done, issue_valid, busy});
      end
   endtask

   task automatic test_normal();
      run_tile("normal", 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_tile("backpressure", 1'b0, 1);
   endtask

   task automatic test_start_held();
      run_tile("start_held", 1'b1, 0);
   endtask

   task automatic test_degenerate();
      num_w_groups = 8'd2;
      num_a_groups = 12'd0;
      bitwidth     = 2'b01;
      start        = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({done, issue_valid, busy, error} !== 4'b1010) begin
         errors++;
         $display("FAIL zero_groups_done got=%b want=1010", {done, issue_valid, busy, error});
      end
      tick();
      checks++;
      if ({done, issue_valid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL zero_groups_idle got=%b want=000", {done, issue_valid, busy});
      end
      num_a_groups = 12'd3;
      bitwidth     = 2'b11;
      start        = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({done, issue_valid, busy, error} !== 4'b1011) begin
         errors++;
         $display("FAIL illegal_bw_done got=%b want=1011", {done, issue_valid, busy, error});
      end
      tick();
      checks++;
      if ({done, issue_valid, busy, error} !== 4'b0001) begin
         errors++;
         $display("FAIL illegal_bw_sticky got=%b want=0001", {done, issue_valid, busy, error});
      end
      // A legal start clears error; run_tile checks error=0 at done.
      run_tile("after_illegal", 1'b0, 0);
   endtask

   task automatic test_overflow();
      logic [15:0] want_base;
      num_w_groups = 8'd1;
      num_a_groups = 12'd300;
      bitwidth     = 2'b00;
      span_all_255 = 1'b1;
      issue_ready  = 1'b1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         want_base = 16'(i * 255);
         checks++;
         if ({issue_valid, a_group, a_base, lanes, error} !== {1'b1, 12'(i), want_base, 5'd16, (i >= 258)}) begin
            errors++;
            $display("FAIL overflow_issue%0d got v=%b a=%0d ab=%0d l=%0d e=%b want a=%0d ab=%0d l=16 e=%b",
                     i, issue_valid, a_group, a_base, lanes, error, i, want_base, (i >= 258));
         end
         tick();
      end
      checks++;
      if ({done, error} !== 2'b11) begin
         errors++;
         $display("FAIL overflow_done got=%b want=11", {done, error});
      end
      span_all_255 = 1'b0;
      tick();
   endtask

   task automatic test_abort_reset();
      num_w_groups = 8'd2;
      num_a_groups = 12'd3;
      bitwidth     = 2'b01;
      issue_ready  = 1'b1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checks++;
      if ({issue_valid, a_group} !== {1'b1, 12'd2}) begin
         errors++;
         $display("FAIL abort_at_issue3 got v=%b a=%0d want v=1 a=2", issue_valid, a_group);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({issue_valid, busy, done, w_group, a_group, a_base} !== 39'd0) begin
         errors++;
         $display("FAIL abort_idle got=%h want=0", {issue_valid, busy, done, w_group, a_group, a_base});
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done got=%b want=0", done);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++;
      if ({issue_valid, busy, done, error, w_group, a_group, w_base, a_base, lanes, first_a} !== 61'd0) begin
         errors++;
         $display("FAIL midtile_reset got=%h want=0",
                  {issue_valid, busy, done, error, w_group, a_group, w_base, a_base, lanes, first_a});
      end
      run_tile("replay", 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_degenerate();
      test_overflow();
      test_abort_reset();
      test_start_held();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
